// File: rtl/vga_gpu_pkg.sv
// Shared VGA GPU definitions: background modes, command encoding, register map helpers.
package vga_gpu_pkg;

  typedef enum logic [1:0] {
    BG_BLACK  = 2'd0,
    BG_COLOR  = 2'd1,
    BG_RAND   = 2'd2,
    BG_BLACK3 = 2'd3
  } bg_mode_e;

  typedef enum logic {
    CMD_IDLE = 1'b0,
    CMD_DATA = 1'b1
  } cmd_state_e;

  localparam int          CMD_ADDR_BIT = 7;
  localparam logic [7:0]  RST_BG_COLOR = 8'h3B;
  localparam logic [7:0]  RST_CTRL     = {6'd0, BG_COLOR};

  // Layer registers first, then control, then background colour.
  function automatic int num_regs(input int nl);
    return nl + 2;
  endfunction

  function automatic logic [7:0] reg_reset_val(input int idx, input int nl);
    if (idx == nl)          return RST_CTRL;
    else if (idx == nl + 1) return RST_BG_COLOR;
    else                    return 8'h00;
  endfunction

endpackage

// File: rtl/vga_layer_mixer_if.sv
// Byte stream from the SPI peripheral into the layer mixer's command decoder.
interface vga_layer_mixer_if;
  logic       ss_n;
  logic [7:0] rx_byte;
  logic       rx_valid;

  modport master (output ss_n, output rx_byte, output rx_valid);
  modport slave  (input  ss_n, input  rx_byte, input  rx_valid);
endinterface

// File: rtl/vga_priority_select.sv
// Combinational first-hit picker: the lowest-index asserted layer supplies the colour.
module vga_priority_select #(
  parameter int NUM_LAYERS = 2,
  parameter int COLOR_W    = 6
) (
  input  logic [NUM_LAYERS-1:0]              hit_mask,
  input  logic [NUM_LAYERS-1:0][COLOR_W-1:0] colors,
  output logic                               hit,
  output logic [COLOR_W-1:0]                 color
);

  // Walk downward so the lowest index is assigned last and wins.
  always_comb begin
    hit   = 1'b0;
    color = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit_mask[i]) begin
        hit   = 1'b1;
        color = colors[i];
      end
    end
  end

endmodule

// File: rtl/vga_layer_mixer.sv
// Byte-stream configured layer compositor with frame-boundary shadowed register file.
module vga_layer_mixer
  import vga_gpu_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int COLOR_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  vga_layer_mixer_if.slave      spi,
  input  logic                  frame_start,
  input  logic                  active,
  input  logic [NUM_LAYERS-1:0] layer_pix,
  input  logic [COLOR_W-1:0]    rand_rgb,
  output logic [COLOR_W-1:0]    rgb_out,
  output logic                  cfg_pending,
  output logic                  cmd_err
);

  localparam int NREGS    = num_regs(NUM_LAYERS);
  localparam int CTRL_IDX = NUM_LAYERS;
  localparam int BG_IDX   = NUM_LAYERS + 1;
  localparam int IDX_W    = $clog2(NREGS + 1);

  logic [NREGS-1:0][7:0] stage_q, act_q;
  logic                  dirty_q, err_q;
  cmd_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_en, err_set, commit;

  // ss_n and bytes only matter while enabled; a disabled block holds its FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    err_set = 1'b0;
    if (ena) begin
      if (spi.ss_n) begin
        state_d = CMD_IDLE;
      end else if (spi.rx_valid) begin
        case (state_q)
          CMD_IDLE: begin
            if (spi.rx_byte[CMD_ADDR_BIT]) begin
              if (spi.rx_byte[6:0] < 7'(NREGS)) begin
                idx_d   = IDX_W'(spi.rx_byte[6:0]);
                state_d = CMD_DATA;
              end else begin
                err_set = 1'b1;
              end
            end
          end
          CMD_DATA: begin
            wr_en = 1'b1;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NREGS - 1)) state_d = CMD_IDLE;
          end
          default: state_d = CMD_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CMD_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign commit = frame_start && dirty_q;

  // Commit samples pre-write staging; a coincident write keeps dirty set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        stage_q[i] <= reg_reset_val(i, NUM_LAYERS);
        act_q[i]   <= reg_reset_val(i, NUM_LAYERS);
      end
      dirty_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (commit) act_q <= stage_q;
      for (int i = 0; i < NREGS; i++)
        if (wr_en && idx_q == IDX_W'(i)) stage_q[i] <= spi.rx_byte;
      if (wr_en)       dirty_q <= 1'b1;
      else if (commit) dirty_q <= 1'b0;
      if (err_set)     err_q   <= 1'b1;
    end
  end

  logic [NUM_LAYERS-1:0]              lay_en;
  logic [NUM_LAYERS-1:0][COLOR_W-1:0] lay_col;
  logic                               lay_hit;
  logic [COLOR_W-1:0]                 lay_rgb, bg_rgb, rgb_d;

  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      lay_en[i]  = act_q[i][7];
      lay_col[i] = act_q[i][COLOR_W-1:0];
    end
  end

  vga_priority_select #(.NUM_LAYERS(NUM_LAYERS), .COLOR_W(COLOR_W)) u_psel (
    .hit_mask (layer_pix & lay_en),
    .colors   (lay_col),
    .hit      (lay_hit),
    .color    (lay_rgb)
  );

  always_comb begin
    case (bg_mode_e'(act_q[CTRL_IDX][1:0]))
      BG_COLOR: bg_rgb = act_q[BG_IDX][COLOR_W-1:0];
      BG_RAND:  bg_rgb = rand_rgb;
      default:  bg_rgb = '0;
    endcase
    rgb_d = active ? (lay_hit ? lay_rgb : bg_rgb) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rgb_out <= '0;
    else        rgb_out <= rgb_d;
  end

  assign cfg_pending = dirty_q;
  assign cmd_err     = err_q;

endmodule

// File: doc/vga_layer_mixer.md
# vga_layer_mixer

Parametrised successor to the fixed 4-way pixel multiplexer and single 32-bit configuration word in the VGA GPU top level. Accepts a byte stream from the SPI peripheral, decodes it into an addressed register file of per-layer colours and enables, and shadows that file so changes apply only at frame boundaries (tear-free). Each pixel it composites up to NUM_LAYERS 1-bit layer masks (character, pong, future sprites) over a selectable background and drives the registered RGB value into the active-video gate.

## Interface
- NUM_LAYERS, 2, number of 1-bit layer inputs (1..8); layer 0 has highest priority
- COLOR_W, 6, output colour width (2 bits per channel at default; max 7)
- clk  input  1  system (pixel) clock
- rst_n  input  1  synchronous active-low reset
- ena  input  1  design enable; when low, byte stream ignored and FSM held
- ss_n  input  1  SPI select, active low; high aborts/ends any transaction
- rx_byte  input  8  byte from SPI peripheral
- rx_valid  input  1  one-cycle strobe, rx_byte valid
- frame_start  input  1  one-cycle pulse at first pixel of frame
- active  input  1  active video region
- layer_pix  input  NUM_LAYERS  per-layer pixel hit at current coordinate
- rand_rgb  input  COLOR_W  random-noise colour
- rgb_out  output  COLOR_W  composited colour; reset 0
- cfg_pending  output  1  staged writes not yet committed; reset 0
- cmd_err  output  1  sticky, bad address seen; reset 0, cleared only by reset

## Operation
- Register map (NUM_REGS = NUM_LAYERS+2, 8 bits each): index i < NUM_LAYERS: bit7 enable, bits[COLOR_W-1:0] colour; index NUM_LAYERS: control, bits[1:0] bg mode (0 black, 1 bg colour, 2 rand_rgb, 3 black); index NUM_LAYERS+1: bg colour.
- Reset: staging and active copies = layers disabled, colour 0; mode 1; bg colour 6'h3B (truncated/zero-extended to COLOR_W).
- Command FSM states IDLE, DATA.
  - IDLE, rx_valid, bit7=1, bits[6:0] < NUM_REGS: latch index -> DATA.
  - IDLE, bit7=0: ignored. bit7=1 with index >= NUM_REGS: set cmd_err, stay IDLE.
  - DATA, rx_valid: write rx_byte to staging[index], set dirty, index+1; index past NUM_REGS-1 -> IDLE (no wrap).
  - ss_n high in any state -> IDLE next cycle, byte in that cycle discarded.
- Commit: on frame_start with dirty set, copy full staging to active, clear dirty. cfg_pending = dirty.
- Write and frame_start same cycle: commit copies pre-write staging; write lands in staging, dirty stays set (commits next frame).
- Composite from active copy: lowest-index layer with enable=1 and layer_pix=1 wins its colour; else background per mode.
- rgb_out = active ? composite : 0.

## Timing
- rgb_out registered: inputs at cycle N appear at N+1; upstream x/y alignment accounts for 1 cycle.
- Staging write visible in staging the cycle after rx_valid; visible on rgb_out no earlier than the pixel 1 cycle after next frame_start.
- rx_valid accepted every cycle (no backpressure); back-to-back bytes legal.
- Reset mid-transaction: FSM to IDLE, all registers to defaults, dirty cleared.
- ena low: rx_valid ignored, FSM state held; commit and compositing continue.

## Structure
- Shared package vga_gpu_pkg: bg-mode encodings, command bit7 flag, reset colour constant, register-index helpers (NUM_REGS function of NUM_LAYERS).
- One sub-module natural: vga_priority_select (combinational first-hit layer picker, parametrised NUM_LAYERS/COLOR_W); FSM, register file and output register in top.

## Test plan
- Reset, active=1, no layer hits -> rgb_out 6'h3B one cycle after active; cfg_pending 0, cmd_err 0.
- Bytes 0x80, 0x85, 0x8A (layer0 en colour 5, layer1 en colour 10), frame_start; both layer_pix=1 -> rgb_out 5; only layer1 -> 10; cfg_pending 1 until frame_start, then 0.
- Write 0x82,0x02 (mode rand) without frame_start -> background still 6'h3B; after frame_start rgb_out tracks rand_rgb delayed 1 cycle.
- Write to layer0 on same cycle as frame_start -> unchanged this frame, applied at following frame_start.
- Address byte 0xFF -> cmd_err 1, no register changes; ss_n high mid-burst -> next data byte ignored until new address.
- active=0 with layer hits -> rgb_out 0; rst_n low mid-burst -> all defaults restored next cycle.
